// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared states, error codes and defaults for the UART frame controller
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - payload buffer, one write port and one combinational read port
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - SYNC/LEN/payload[/checksum] frame parser with verified-only payload release
// Checksum byte and its check are present only when UART_FRAME_CSUM_EN is defined.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       byte_available,
    output logic       rx_enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    frame_state_t  state, state_nxt;
    logic          ba_q;
    logic          strobe;
    logic [PW-1:0] len;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] rd_ptr;
    logic [TW-1:0] to_cnt;
    logic          cnt_active;
    logic          timeout;
    logic          len_bad;
    logic          buf_we;
    logic          xfer;
    logic          err_det;
    logic [1:0]    err_nxt;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]    sum;
    logic [7:0]    sum_add;
`endif

    assign strobe     = byte_available & ~ba_q;
    assign wr_ptr_inc = wr_ptr + PW'(1);
    assign len_bad    = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN));
    assign cnt_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout    = cnt_active && !strobe && (to_cnt == TO_LAST);
    assign xfer       = out_valid && out_ready;
    assign out_last   = out_valid && (rd_ptr == len - PW'(1));
`ifdef UART_FRAME_CSUM_EN
    assign sum_add    = sum + rx_byte;
`endif

    frame_buf #(
        .DEPTH(MAX_LEN),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(rx_byte),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_det   = 1'b0;
        err_nxt   = ERR_NONE;
        buf_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (strobe && rx_byte == SYNC_BYTE) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (strobe) begin
                    if (len_bad) begin
                        state_nxt = ST_IDLE;
                        err_det   = 1'b1;
                        err_nxt   = ERR_LEN;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (strobe) begin
                    buf_we = 1'b1;
                    if (wr_ptr_inc == len) begin
`ifdef UART_FRAME_CSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_DRAIN;
`endif
                    end
                end
            end
`ifdef UART_FRAME_CSUM_EN
            ST_CSUM: begin
                if (strobe) begin
                    if (sum_add == 8'd0) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_det   = 1'b1;
                        err_nxt   = ERR_CSUM;
                    end
                end
            end
`endif
            ST_DRAIN: begin
                if (xfer && out_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout) begin
            state_nxt = ST_IDLE;
            err_det   = 1'b1;
            err_nxt   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ba_q      <= 1'b0;
            rx_enable <= 1'b0;
            out_valid <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            len       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            to_cnt    <= '0;
`ifdef UART_FRAME_CSUM_EN
            sum       <= '0;
`endif
        end else begin
            ba_q      <= byte_available;
            rx_enable <= (state_nxt != ST_DRAIN);
            frame_ok  <= (state_nxt == ST_DRAIN) && (state != ST_DRAIN);
            frame_err <= err_det;
            if (err_det) begin
                err_code <= err_nxt;
            end
            if (state == ST_LEN && strobe) begin
                len    <= rx_byte[PW-1:0];
                wr_ptr <= '0;
`ifdef UART_FRAME_CSUM_EN
                sum    <= rx_byte;
`endif
            end
            if (buf_we) begin
                wr_ptr <= wr_ptr_inc;
`ifdef UART_FRAME_CSUM_EN
                sum    <= sum_add;
`endif
            end
            // Valid rises the cycle after DRAIN entry and drops with the last transfer.
            out_valid <= (state == ST_DRAIN) && !(xfer && out_last);
            if (state != ST_DRAIN) begin
                rd_ptr <= '0;
            end else if (xfer) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (!cnt_active || strobe) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       byte_available = 1'b0;
    logic       rx_enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    uart_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .byte_available(byte_available),
        .rx_enable     (rx_enable),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         low_cnt = 0;
    int         vcnt = 0;
    int         stall_cnt = 0;
    int         stall_bad = 0;
    logic [1:0] ok_flags = 2'b11;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic [7:0] q_data [$];
    logic       q_last [$];
    int         q_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (frame_ok) begin
                ok_cnt++;
                ok_flags = {rx_enable, out_valid};
            end
            if (frame_err) err_cnt++;
            if (!rx_enable) low_cnt++;
            if (out_valid) vcnt++;
            if (stall_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_bad++;
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ok_cnt = 0; err_cnt = 0; low_cnt = 0; vcnt = 0;
        stall_cnt = 0; stall_bad = 0; ok_flags = 2'b11;
        q_data.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        byte_available = 1'b1;
        tick(2);
        byte_available = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [7:0] n, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic bad);
        logic [7:0] d [3];
        logic [7:0] sum;
        logic [7:0] csum;
        d[0] = d0; d[1] = d1; d[2] = d2;
        send_byte(8'hA5);
        send_byte(n);
        sum = n;
        for (int i = 0; i < int'(n); i++) begin
            send_byte(d[i]);
            sum = sum + d[i];
        end
        csum = 8'h00 - sum + {7'd0, bad};
`ifdef UART_FRAME_CSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic wait_xfers(input int n);
        for (int i = 0; i < 300 && q_data.size() < n; i++) tick(1);
        tick(4);
    endtask

    task automatic verify_frame(input string tag, input int n, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        check({tag, "_xfers"}, q_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size()) begin
                check({tag, "_data"}, q_data[i], d[i]);
                check({tag, "_last"}, q_last[i], (i == n - 1));
            end
        end
        check({tag, "_ok"}, ok_cnt, 1);
        check({tag, "_err"}, err_cnt, 0);
    endtask

    initial begin
        tick(2);
        check("rst_rxen", rx_enable, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_ok", frame_ok, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_code", err_code, 2'd0);
        rst = 1'b0;
        check("rxen_pre", rx_enable, 1'b0);
        tick(1);
        check("rxen_post", rx_enable, 1'b1);

        // basic frame, continuous ready
        clear_mon();
        out_ready = 1'b1;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 1'b0);
        wait_xfers(3);
        tick(10);
        verify_frame("t1", 3, 8'h11, 8'h22, 8'h33);
        if (q_cyc.size() == 3) check("t1_consec", q_cyc[2] - q_cyc[0], 2);
        check("t1_ok_flags", ok_flags, 2'b00);
        check("t1_low_cycles", low_cnt, 4);
        check("t1_rxen_idle", rx_enable, 1'b1);

`ifdef UART_FRAME_CSUM_EN
        clear_mon();
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 1'b1);
        tick(20);
        check("t2_err", err_cnt, 1);
        check("t2_code", err_code, 2'd2);
        check("t2_valid", vcnt, 0);
        check("t2_ok", ok_cnt, 0);
`endif

        // bad lengths, junk, then resync
        clear_mon();
        send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h11);
        tick(5);
        check("t3_err", err_cnt, 2);
        check("t3_code", err_code, 2'd1);
        send_byte(8'h3C);
        check("t3_junk", err_cnt, 2);
        clear_mon();
        send_frame(8'd2, 8'hAA, 8'h55, 8'h00, 1'b0);
        wait_xfers(2);
        verify_frame("t3", 2, 8'hAA, 8'h55, 8'h00);

        // inter-byte timeout
        clear_mon();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        tick(11900);
        check("t4_early", err_cnt, 0);
        for (int i = 0; i < 300 && err_cnt == 0; i++) tick(1);
        check("t4_err", err_cnt, 1);
        check("t4_code", err_code, 2'd3);
        clear_mon();
        send_frame(8'd3, 8'h44, 8'h55, 8'h66, 1'b0);
        wait_xfers(3);
        verify_frame("t4", 3, 8'h44, 8'h55, 8'h66);

        // ready toggling during DRAIN
        clear_mon();
        out_ready = 1'b0;
        fork
            send_frame(8'd3, 8'h11, 8'h22, 8'h33, 1'b0);
            for (int i = 0; i < 60; i++) begin
                tick(1);
                out_ready = ~out_ready;
            end
        join
        out_ready = 1'b1;
        wait_xfers(3);
        verify_frame("t5", 3, 8'h11, 8'h22, 8'h33);
        check("t5_stable", stall_bad, 0);
        check("t5_stalled", (stall_cnt >= 2), 1'b1);

        // reset mid-payload
        clear_mon();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        #1;
        check("t6_rxen", rx_enable, 1'b0);
        check("t6_valid", out_valid, 1'b0);
        check("t6_ok", frame_ok, 1'b0);
        check("t6_err", frame_err, 1'b0);
        check("t6_code", err_code, 2'd0);
        tick(2);
        rst = 1'b0;
        check("t6_rxen_pre", rx_enable, 1'b0);
        tick(1);
        check("t6_rxen_post", rx_enable, 1'b1);
        send_frame(8'd3, 8'h77, 8'h88, 8'h99, 1'b0);
        wait_xfers(3);
        verify_frame("t6", 3, 8'h77, 8'h88, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame-level controller sitting directly behind `uart_rx` on the icestick. It gates the receiver through `rx_enable` and picks each byte off the rising edge of `byte_available`. It parses SYNC/LEN/payload/checksum frames into an internal buffer and releases a payload downstream over a valid/ready stream only after the whole frame has been verified. Bad, oversize or stalled frames are dropped and reported, and downstream never sees a partial frame.

## Interface
- `MAX_LEN`, 16: maximum payload bytes; the internal buffer depth.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 12000: allowed inter-byte gap inside a frame (1 ms at 12 MHz).
- `clk` in 1: system clock, 12 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_byte` in 8: byte from `uart_rx`; valid when `byte_available` rises.
- `byte_available` in 1: receiver byte-complete level.
- `rx_enable` out 1: enables receiver start-bit detection.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts.
- `out_last` out 1: final payload byte of the frame.
- `frame_ok` out 1: one-cycle pulse when a frame is verified.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.
- `err_code` out 2: last error; 1 = bad LEN, 2 = checksum mismatch, 3 = timeout. Holds until the next error.

## Operation
- Byte strobe:
  - `byte_available` is registered once.
  - strobe = current & ~previous. Each strobe captures `rx_byte` once.
- States are IDLE, LEN, PAYLOAD, CSUM and DRAIN.
- **IDLE:** wait for a strobe carrying `SYNC_BYTE`; any other byte is discarded silently → LEN.
- **LEN:**
  - If LEN is 0 or greater than `MAX_LEN`: error 1 → IDLE.
  - Otherwise: latch LEN, set the running sum to LEN, clear the write pointer → PAYLOAD.
- **PAYLOAD:**
  - Each strobe writes the buffer at the write pointer, adds the byte to the sum and increments the pointer.
  - After LEN bytes → CSUM.
- **CSUM:**
  - sum + byte, taken mod 256, equal to 0: pulse `frame_ok` → DRAIN.
  - Otherwise: error 2 → IDLE.
- **DRAIN:**
  - `rx_enable` is 0; bytes arriving here are lost by design.
  - Streams buffer[0..LEN-1] with read pointer `rd`.
  - A transfer happens on `out_valid & out_ready`.
  - `out_last` = (`rd` == LEN-1).
  - After the last transfer → IDLE.
- **Timeout:**
  - An inter-byte counter runs in LEN, PAYLOAD and CSUM and clears on every strobe.
  - Reaching `TIMEOUT_CLKS`-1 gives error 3 → IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- Arithmetic widths:
  - Sum is 8-bit with wrap.
  - Pointers are $clog2(`MAX_LEN`+1) bits.
  - Timeout counter is $clog2(`TIMEOUT_CLKS`) bits.

## Timing
- Reset values:
  - state IDLE.
  - `rx_enable` 0; it is registered and goes to 1 on the first clock after `rst` deasserts.
  - `out_valid`, `out_last`, `frame_ok` and `frame_err` are 0.
  - `err_code` is 0.
  - All pointers, the sum and the counter are 0.
- Strobe latency: the state or buffer update is visible 1 cycle after the `byte_available` rising edge.
- `frame_ok` pulses in the cycle DRAIN is entered. `out_valid` is asserted from the next cycle.
- Buffer read is combinational, giving one byte per cycle under continuous `out_ready`.
- Handshake:
  - `out_valid` is never deasserted without a transfer.
  - `out_data` and `out_last` are stable while stalled.
- `rx_enable` returns to 1 one cycle after the last transfer.
- `frame_err` pulses in the cycle the error is detected. `err_code` updates in the same cycle.
- A strobe and a timeout in the same cycle: the strobe wins (byte processed, counter cleared).
- `rst` asserted mid-frame or mid-DRAIN: immediate return to reset values. The buffered frame is discarded and no `frame_err` is emitted.

## Configuration
- `UART_FRAME_CSUM_EN` defined:
  - CSUM state exists and the checksum is checked as above.
- Not defined:
  - There is no checksum byte and no sum logic.
  - PAYLOAD → DRAIN directly after the LEN-th byte, with `frame_ok` pulsing on that transition.
  - `err_code` 2 is never produced.

## Structure
- Shared package `uart_frame_pkg`:
  - state enum.
  - error-code constants (NONE/LEN/CSUM/TIMEOUT).
  - default `SYNC_BYTE`.
- Sub-module `frame_buf`: a `MAX_LEN`×8 flop array with one write port and one combinational read port.

## Test plan
- Frame A5 03 11 22 33 97, `out_ready`=1 → `frame_ok` pulse; out 11, 22, 33 on consecutive cycles; `out_last` on 33; `rx_enable` low only during DRAIN.
- Same frame with checksum 98 → `frame_err` pulse, `err_code`=2, no `out_valid`.
- A5 00, then A5 with LEN 17 (`MAX_LEN`=16) → two `frame_err` pulses, `err_code`=1, and the parser resyncs on the next A5.
- A5 03 11 followed by a 12000-cycle gap → `frame_err`, `err_code`=3; next valid frame is accepted.
- `out_ready` toggled 1/0 each cycle during DRAIN → each byte held stable while stalled; 3 transfers, no duplicates.
- `rst` pulsed during PAYLOAD → all outputs at reset values; `rx_enable` returns to 1 one cycle after release; subsequent frame correct.
